// File: rtl/vga_timing.sv
// VGA 800x600@60 timing generator: cascaded pixel/line counters with registered
// sync and blanking flags aligned to the counters they accompany.

package vga_pkg;

  parameter int unsigned HOR_PIXELS      = 800;
  parameter int unsigned VER_PIXELS      = 600;

  parameter int unsigned HOR_TOTAL_TIME  = 1056;
  parameter int unsigned HOR_BLANK_START = HOR_PIXELS;
  parameter int unsigned HOR_SYNC_START  = 840;
  parameter int unsigned HOR_SYNC_TIME   = 128;

  parameter int unsigned VER_TOTAL_TIME  = 628;
  parameter int unsigned VER_BLANK_START = VER_PIXELS;
  parameter int unsigned VER_SYNC_START  = 601;
  parameter int unsigned VER_SYNC_TIME   = 4;

endpackage

module vga_timing #(
  parameter int unsigned HOR_TOTAL_TIME  = vga_pkg::HOR_TOTAL_TIME,
  parameter int unsigned HOR_BLANK_START = vga_pkg::HOR_BLANK_START,
  parameter int unsigned HOR_SYNC_START  = vga_pkg::HOR_SYNC_START,
  parameter int unsigned HOR_SYNC_TIME   = vga_pkg::HOR_SYNC_TIME,
  parameter int unsigned VER_TOTAL_TIME  = vga_pkg::VER_TOTAL_TIME,
  parameter int unsigned VER_BLANK_START = vga_pkg::VER_BLANK_START,
  parameter int unsigned VER_SYNC_START  = vga_pkg::VER_SYNC_START,
  parameter int unsigned VER_SYNC_TIME   = vga_pkg::VER_SYNC_TIME
) (
  input  logic        clk,
  input  logic        rst,
  output logic [10:0] hcount,
  output logic        hsync,
  output logic        hblnk,
  output logic [10:0] vcount,
  output logic        vsync,
  output logic        vblnk
);

  // Bounds are held in 12 bits because a sync window may end exactly at 2048.
  localparam logic [10:0] HLast      = 11'(HOR_TOTAL_TIME - 1);
  localparam logic [10:0] VLast      = 11'(VER_TOTAL_TIME - 1);
  localparam logic [11:0] HBlank     = 12'(HOR_BLANK_START);
  localparam logic [11:0] HSyncStart = 12'(HOR_SYNC_START);
  localparam logic [11:0] HSyncEnd   = 12'(HOR_SYNC_START + HOR_SYNC_TIME);
  localparam logic [11:0] VBlank     = 12'(VER_BLANK_START);
  localparam logic [11:0] VSyncStart = 12'(VER_SYNC_START);
  localparam logic [11:0] VSyncEnd   = 12'(VER_SYNC_START + VER_SYNC_TIME);

  if (HOR_BLANK_START > HOR_SYNC_START || HOR_SYNC_START + HOR_SYNC_TIME > HOR_TOTAL_TIME ||
      HOR_TOTAL_TIME > 2048) begin : g_bad_hor
    $error("vga_timing: inconsistent horizontal timing parameters");
  end
  if (VER_BLANK_START > VER_SYNC_START || VER_SYNC_START + VER_SYNC_TIME > VER_TOTAL_TIME ||
      VER_TOTAL_TIME > 2048) begin : g_bad_ver
    $error("vga_timing: inconsistent vertical timing parameters");
  end

  logic [10:0] hcount_q, hcount_d;
  logic [10:0] vcount_q, vcount_d;
  logic        hsync_q, hsync_d;
  logic        hblnk_q, hblnk_d;
  logic        vsync_q, vsync_d;
  logic        vblnk_q, vblnk_d;
  logic        h_wrap;

  always_comb begin
    h_wrap   = (hcount_q == HLast);
    hcount_d = h_wrap ? 11'd0 : hcount_q + 11'd1;

    vcount_d = vcount_q;
    if (h_wrap) begin
      vcount_d = (vcount_q == VLast) ? 11'd0 : vcount_q + 11'd1;
    end

    // Flags decode the next counter values so they land on the same edge as the counters.
    hblnk_d = ({1'b0, hcount_d} >= HBlank);
    hsync_d = ({1'b0, hcount_d} >= HSyncStart) && ({1'b0, hcount_d} < HSyncEnd);
    vblnk_d = ({1'b0, vcount_d} >= VBlank);
    vsync_d = ({1'b0, vcount_d} >= VSyncStart) && ({1'b0, vcount_d} < VSyncEnd);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_q <= 11'd0;
      vcount_q <= 11'd0;
      hsync_q  <= 1'b0;
      hblnk_q  <= 1'b0;
      vsync_q  <= 1'b0;
      vblnk_q  <= 1'b0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      hsync_q  <= hsync_d;
      hblnk_q  <= hblnk_d;
      vsync_q  <= vsync_d;
      vblnk_q  <= vblnk_d;
    end
  end

  assign hcount = hcount_q;
  assign vcount = vcount_q;
  assign hsync  = hsync_q;
  assign hblnk  = hblnk_q;
  assign vsync  = vsync_q;
  assign vblnk  = vblnk_q;

endmodule

// File: doc/vga_timing.md
# vga_timing

Free-running 800x600 @ 60 Hz VGA timing generator, clocked at 40 MHz. It consumes the resolution constants of `vga_pkg` (HOR_PIXELS, VER_PIXELS) plus the porch and sync constants defined below. It produces the horizontal and vertical pixel counters, sync strobes and blanking flags. It is the first stage of the video pipeline, and every downstream draw/background/rect stage consumes its six outputs.

## Interface
Parameters (all timing values are in pixel clocks or lines, and all are added to `vga_pkg`):
- HOR_TOTAL_TIME, 1056, pixels per line.
- HOR_BLANK_START, 800 (= HOR_PIXELS), first blanked pixel.
- HOR_SYNC_START, 840, first hsync pixel.
- HOR_SYNC_TIME, 128, hsync width.
- VER_TOTAL_TIME, 628, lines per frame.
- VER_BLANK_START, 600 (= VER_PIXELS), first blanked line.
- VER_SYNC_START, 601, first vsync line.
- VER_SYNC_TIME, 4, vsync width.

Ports:
- clk  in  1  40 MHz pixel clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- hcount  out  11  current pixel in the line, 0..1055.
- hsync  out  1  high while hcount is in 840..967.
- hblnk  out  1  high while hcount is in 800..1055.
- vcount  out  11  current line, 0..627.
- vsync  out  1  high while vcount is in 601..604.
- vblnk  out  1  high while vcount is in 600..627.

## Operation
- The horizontal counter runs 0..HOR_TOTAL_TIME-1 and then wraps to 0.
- The vertical counter advances by 1 only in the cycle where hcount wraps from 1055 to 0. It runs 0..VER_TOTAL_TIME-1 and then wraps to 0.
  - At the frame end (hcount=1055, vcount=627) both counters return to 0 on the same edge.
- Flags are pure functions of the counter value they accompany:
  - hblnk = (hcount >= HOR_BLANK_START).
  - hsync = (hcount >= HOR_SYNC_START) and (hcount < HOR_SYNC_START+HOR_SYNC_TIME).
  - vblnk = (vcount >= VER_BLANK_START).
  - vsync = (vcount >= VER_SYNC_START) and (vcount < VER_SYNC_START+VER_SYNC_TIME).
- Syncs are active-high, matching the VESA 800x600@60 positive polarity.
- The vertical flags depend only on vcount. They therefore change on the same edge as vcount and stay constant across the whole line.
- Arithmetic and widths:
  - The counters are 11-bit unsigned and never exceed their TOTAL-1 value.
  - Next-value comparisons use equality with TOTAL-1, not overflow.
  - Parameters must satisfy HOR_BLANK_START ≤ HOR_SYNC_START, HOR_SYNC_START+HOR_SYNC_TIME ≤ HOR_TOTAL_TIME, and HOR_TOTAL_TIME ≤ 2048. The same three rules apply vertically.
- There is no state machine beyond the two cascaded counters. There are no inputs other than clk and rst.

## Timing
- All six outputs are registered.
  - The flags are computed from the next counter values, so that in any cycle the flags correspond exactly to the hcount/vcount presented in that cycle, with no 1-cycle skew.
- Reset values: hcount=0, vcount=0, hsync=0, hblnk=0, vsync=0, vblnk=0.
  - Outputs hold these values on every edge sampled with rst=1.
- First edge with rst=0 gives hcount=1, vcount=0. Pixel (0,0) is therefore the reset-hold state.
- Reset asserted mid-frame, e.g. at hcount=500, vcount=300:
  - The next edge forces all outputs to their reset values.
  - Counting restarts from 0 on release.
  - No partial line or partial sync pulse survives.
- Line period is exactly 1056 clocks and frame period exactly 663168 clocks (26.4 µs and 16.58 ms at 40 MHz).
- Pulse widths:
  - hsync is high for exactly 128 consecutive clocks per line.
  - vsync is high for exactly 4 lines = 4224 clocks per frame.
  - hblnk is high for 256 clocks per line.
  - vblnk is high for 28 lines.

## Test plan
- Reset hold and release:
  - Hold rst=1 for 5 clocks, all outputs must be 0.
  - Deassert rst; next edge must give hcount=1, vcount=0, all flags 0.
- Horizontal boundaries on line 0:
  - At hcount=799, hblnk=0. At hcount=800, hblnk=1.
  - At hcount=839, hsync=0. At hcount=840, hsync=1.
  - At hcount=967, hsync=1. At hcount=968, hsync=0.
  - At hcount=1055, hblnk=1. The next edge gives hcount=0, hblnk=0, vcount=1.
- Vertical boundaries:
  - The vcount 599→600 transition sets vblnk=1 at hcount=0.
  - vsync rises at vcount=601, hcount=0 and falls at vcount=605, hcount=0.
  - vsync stays high through all 1056 hcount values of lines 601..604.
- Frame wrap: at hcount=1055, vcount=627, the next edge must give hcount=0, vcount=0, vblnk=0, vsync=0, hblnk=0.
- Periodicity over 3 full frames:
  - Rising-edge spacing must be exactly 1056 clocks for hsync and 663168 clocks for vsync.
  - hsync high count must be 128 per line, and vsync high count must be 4224 clocks per frame.
- Mid-frame reset:
  - Assert rst at hcount=500, vcount=300 for 1 clock.
  - The next edge must give all outputs = 0.
  - After release, the first hsync rise must occur 840 clocks after the reset edge.
